tx_frame_scheduler: RTL and testbench
=====================================

Name: tx_frame_scheduler

Overview:
Frame-level controller for the BPSK transmit path. Arbitrates between two packet sources: req[0] is the UART byte-packet buffer and req[1] is the debug/telemetry source. It sequences each frame into the parallel-serial converter in this order: sync word, payload, optional CRC, then an inter-frame gap. It sits between the packet sources/sorter and the serializer/modulator. It is the only block that issues serializer loads.

Parameters:
PACKET_WIDTH, 11, payload bytes per packet; W = PACKET_WIDTH*8.
SYNC_BITS, 16, sync word length in bits; must satisfy 8 <= SYNC_BITS <= W.
SYNC_WORD, 16'hD391, sync pattern, sent MSB first.
GAP_TICKS, 64, bit_tick periods of silence after each frame; 0 means no gap.
LEN_W, $clog2(W+1), width of ser_len.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
bit_tick  in  1  one-cycle strobe per transmitted bit period
req  in  2  per-source request; held high until that source's ack
packet0  in  W  source 0 payload; byte PACKET_WIDTH-1 occupies the MSBs and is sent first
packet1  in  W  source 1 payload
ack  out  2  one-cycle grant/capture pulse per source
ser_load  out  1  one-cycle load pulse to the serializer
ser_word  out  W  segment data, left-justified, MSB sent first
ser_len  out  LEN_W  number of valid bits in ser_word
ser_done  in  1  one-cycle pulse from the serializer after the last bit of a segment
tx_active  out  1  high while a frame segment is on air
busy  out  1  high in every state except IDLE
grant_src  out  1  source of the current or last frame
frame_count  out  16  count of completed frames; wraps 0xFFFF->0

Behaviour:
- Reset values: all outputs 0, state IDLE, rr_last=1 (source 0 wins the first tie), CRC register 0. Async assert, sync release.
- FSM states: IDLE, LOAD_SYNC, WAIT_SYNC, LOAD_PAY, WAIT_PAY, LOAD_CRC, WAIT_CRC, GAP.
- IDLE, on any req:
  - Grant by round-robin: the source not equal to rr_last wins a tie; a single requester wins outright.
  - Same cycle: pulse ack[g], capture packet_g, set grant_src=g and rr_last=g, go to LOAD_SYNC.
  - req-to-ack latency: 1 cycle (ack registered).
- LOAD_SYNC: ser_load=1 for one cycle; ser_word={SYNC_WORD, zeros}; ser_len=SYNC_BITS; tx_active goes to 1; go to WAIT_SYNC.
- WAIT_SYNC: wait for ser_done, then go to LOAD_PAY.
- LOAD_PAY: load the captured packet with ser_len=W; go to WAIT_PAY.
- WAIT_PAY: on ser_done, go to LOAD_CRC if CRC is enabled, else finish the frame.
- LOAD_CRC: load {crc8, zeros} with ser_len=8; go to WAIT_CRC.
- WAIT_CRC: on ser_done, finish the frame.
- Frame finish, same cycle as the final ser_done:
  - tx_active goes to 0 and frame_count increments.
  - Go to GAP if GAP_TICKS>0, else IDLE.
- GAP: count bit_tick pulses; return to IDLE on the GAP_TICKS-th tick. Requests are not granted during GAP.
- ser_done arriving in any non-WAIT state is ignored.
- ser_load is never asserted twice without an intervening ser_done.
- ser_word and ser_len hold their values between loads.
- A new request arriving while busy stays pending; it is granted in IDLE.
- A source that drops req before ack is simply not granted; no error.
- Reset mid-frame: immediate return to IDLE, captured packet discarded, no further loads. The ack already given is not repeated.
- The bit_tick input is only consumed in GAP.

Optional Feature:
TX_CRC_EN.
- Defined:
  - CRC-8 is computed over the captured payload, MSB byte first.
  - Polynomial 0x07, init 0x00, no reflection, no final XOR.
  - Computed one byte per clk starting the cycle after capture.
  - LOAD_CRC waits until all PACKET_WIDTH bytes are processed before loading.
- Undefined: LOAD_CRC, WAIT_CRC and the CRC register are absent; a frame finishes after WAIT_PAY.

Test Plan:
1. Single request: req=01, packet0=88'h0102...0B, GAP_TICKS=4, ser_done returned 20 cycles after each load.
   -> ack=01 one cycle later.
   -> Loads in order: (D391<<(W-16), 16), then (packet0, 88).
   -> frame_count=1, then 4 bit_ticks of GAP, then IDLE.
2. Tie arbitration: req=11 held high continuously.
   -> Grants alternate 0,1,0,1 over four frames; each ack is a single-cycle pulse.
3. CRC check, with TX_CRC_EN and PACKET_WIDTH=9: payload ASCII "123456789".
   -> Third load is ser_word[W-1:W-8]=0xF4 with ser_len=8.
4. Stray completion: ser_done pulsed in IDLE and GAP.
   -> No state change and no ser_load.
   -> A later real frame completes normally.
5. Reset mid-frame: rst asserted in WAIT_PAY.
   -> All outputs 0 asynchronously, state IDLE, frame_count=0.
   -> After release with req=10, source 1 is granted.
6. GAP_TICKS=0 with back-to-back req=01.
   -> Next ack occurs 1 cycle after the final ser_done plus 1 cycle in IDLE; no bit_tick dependency.

Source files
------------

// File: rtl/tx_frame_scheduler.sv
// Frame sequencer for the BPSK transmit path: round-robin grant of two sources, then sync/payload[/CRC]/gap.
// Optional CRC-8 trailer is built when the TX_CRC_EN macro is defined.
module tx_frame_scheduler #(
  parameter int                     PACKET_WIDTH = 11,
  parameter int                     SYNC_BITS    = 16,
  parameter logic [SYNC_BITS-1:0]   SYNC_WORD    = 16'hD391,
  parameter int                     GAP_TICKS    = 64,
  parameter int                     LEN_W        = $clog2(PACKET_WIDTH*8+1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      bit_tick,
  input  logic [1:0]                req,
  input  logic [PACKET_WIDTH*8-1:0] packet0,
  input  logic [PACKET_WIDTH*8-1:0] packet1,
  output logic [1:0]                ack,
  output logic                      ser_load,
  output logic [PACKET_WIDTH*8-1:0] ser_word,
  output logic [LEN_W-1:0]          ser_len,
  input  logic                      ser_done,
  output logic                      tx_active,
  output logic                      busy,
  output logic                      grant_src,
  output logic [15:0]               frame_count
);

  localparam int W = PACKET_WIDTH*8;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_SYNC,
    WAIT_SYNC,
    LOAD_PAY,
    WAIT_PAY,
`ifdef TX_CRC_EN
    LOAD_CRC,
    WAIT_CRC,
`endif
    GAP
  } state_t;

  localparam state_t      DONE_STATE = (GAP_TICKS > 0) ? GAP : IDLE;
  localparam logic [15:0] GAP_LAST   = 16'(GAP_TICKS - 1);

  state_t         state, state_next;
  logic [W-1:0]   pkt;
  logic           rr_last;
  logic [15:0]    gap_cnt;
  logic           gnt;
  logic           do_grant;
  logic           load_sync;
  logic           load_pay;
  logic           finish;

`ifdef TX_CRC_EN
  localparam int CW = $clog2(PACKET_WIDTH+1);

  logic [7:0]     crc;
  logic [W-1:0]   crc_sh;
  logic [CW-1:0]  crc_cnt;
  logic           load_crc;

  function automatic logic [7:0] crc8_byte(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r;
    r = c ^ d;
    for (int unsigned i = 0; i < 8; i++) begin
      r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
    end
    return r;
  endfunction

  // One payload byte per clock, MSB byte first, starting the cycle after capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crc     <= '0;
      crc_sh  <= '0;
      crc_cnt <= '0;
    end else if (do_grant) begin
      crc     <= '0;
      crc_sh  <= gnt ? packet1 : packet0;
      crc_cnt <= CW'(PACKET_WIDTH);
    end else if (crc_cnt != '0) begin
      crc     <= crc8_byte(crc, crc_sh[W-1 -: 8]);
      crc_sh  <= crc_sh << 8;
      crc_cnt <= crc_cnt - CW'(1);
    end
  end
`endif

  // A tie goes to the source that did not win last time.
  assign gnt  = (req == 2'b11) ? ~rr_last : req[1];
  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    do_grant   = 1'b0;
    load_sync  = 1'b0;
    load_pay   = 1'b0;
    finish     = 1'b0;
`ifdef TX_CRC_EN
    load_crc   = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (req != 2'b00) begin
          do_grant   = 1'b1;
          state_next = LOAD_SYNC;
        end
      end
      LOAD_SYNC: begin
        load_sync  = 1'b1;
        state_next = WAIT_SYNC;
      end
      WAIT_SYNC: begin
        if (ser_done) state_next = LOAD_PAY;
      end
      LOAD_PAY: begin
        load_pay   = 1'b1;
        state_next = WAIT_PAY;
      end
      WAIT_PAY: begin
        if (ser_done) begin
`ifdef TX_CRC_EN
          state_next = LOAD_CRC;
`else
          finish     = 1'b1;
          state_next = DONE_STATE;
`endif
        end
      end
`ifdef TX_CRC_EN
      LOAD_CRC: begin
        if (crc_cnt == '0) begin
          load_crc   = 1'b1;
          state_next = WAIT_CRC;
        end
      end
      WAIT_CRC: begin
        if (ser_done) begin
          finish     = 1'b1;
          state_next = DONE_STATE;
        end
      end
`endif
      GAP: begin
        if (bit_tick && gap_cnt == GAP_LAST) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack         <= '0;
      ser_load    <= 1'b0;
      ser_word    <= '0;
      ser_len     <= '0;
      tx_active   <= 1'b0;
      grant_src   <= 1'b0;
      frame_count <= '0;
      pkt         <= '0;
      rr_last     <= 1'b1;
      gap_cnt     <= '0;
    end else begin
      ack      <= '0;
      ser_load <= 1'b0;
      if (do_grant) begin
        ack       <= gnt ? 2'b10 : 2'b01;
        pkt       <= gnt ? packet1 : packet0;
        grant_src <= gnt;
        rr_last   <= gnt;
      end
      if (load_sync) begin
        ser_load  <= 1'b1;
        ser_word  <= W'(SYNC_WORD) << (W - SYNC_BITS);
        ser_len   <= LEN_W'(SYNC_BITS);
        tx_active <= 1'b1;
      end
      if (load_pay) begin
        ser_load <= 1'b1;
        ser_word <= pkt;
        ser_len  <= LEN_W'(W);
      end
`ifdef TX_CRC_EN
      if (load_crc) begin
        ser_load <= 1'b1;
        ser_word <= W'(crc) << (W - 8);
        ser_len  <= LEN_W'(8);
      end
`endif
      if (finish) begin
        tx_active   <= 1'b0;
        frame_count <= frame_count + 16'd1;
      end
      if (state != GAP) begin
        gap_cnt <= '0;
      end else if (bit_tick) begin
        gap_cnt <= gap_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_tx_frame_scheduler.sv
// Directed bench for tx_frame_scheduler: one instance with a 4-tick gap, one with no gap.
// With TX_CRC_EN defined the payload is "123456789" and every frame carries a 0xF4 trailer.
module tb_tx_frame_scheduler;

`ifdef TX_CRC_EN
  localparam int PW = 9;
`else
  localparam int PW = 11;
`endif
  localparam int W  = PW*8;
  localparam int LW = $clog2(W+1);

  logic          clk = 1'b0;
  logic          rst;
  logic          bit_tick;
  logic [1:0]    req;
  logic [W-1:0]  packet0, packet1;
  logic          ser_done;
  logic          sel;

  logic [1:0]    req_a, req_b, ack_a, ack_b, ack_c;
  logic          done_a, done_b;
  logic          load_a, load_b, load_c;
  logic [W-1:0]  word_a, word_b, word_c;
  logic [LW-1:0] len_a, len_b, len_c;
  logic          act_a, act_b, act_c;
  logic          busy_a, busy_b, busy_c;
  logic          gsrc_a, gsrc_b, gsrc_c;
  logic [15:0]   fc_a, fc_b, fc_c;

  int n_checks = 0;
  int n_errors = 0;
  logic [W-1:0] exp_sync;

  always #5 clk = ~clk;

  assign req_a  = sel ? 2'b00 : req;
  assign req_b  = sel ? req : 2'b00;
  assign done_a = sel ? 1'b0 : ser_done;
  assign done_b = sel ? ser_done : 1'b0;
  assign ack_c  = sel ? ack_b  : ack_a;
  assign load_c = sel ? load_b : load_a;
  assign word_c = sel ? word_b : word_a;
  assign len_c  = sel ? len_b  : len_a;
  assign act_c  = sel ? act_b  : act_a;
  assign busy_c = sel ? busy_b : busy_a;
  assign gsrc_c = sel ? gsrc_b : gsrc_a;
  assign fc_c   = sel ? fc_b   : fc_a;

  tx_frame_scheduler #(.PACKET_WIDTH(PW), .GAP_TICKS(4)) dut (
    .clk(clk), .rst(rst), .bit_tick(bit_tick), .req(req_a),
    .packet0(packet0), .packet1(packet1), .ack(ack_a),
    .ser_load(load_a), .ser_word(word_a), .ser_len(len_a), .ser_done(done_a),
    .tx_active(act_a), .busy(busy_a), .grant_src(gsrc_a), .frame_count(fc_a)
  );

  tx_frame_scheduler #(.PACKET_WIDTH(PW), .GAP_TICKS(0)) dut_nogap (
    .clk(clk), .rst(rst), .bit_tick(bit_tick), .req(req_b),
    .packet0(packet0), .packet1(packet1), .ack(ack_b),
    .ser_load(load_b), .ser_word(word_b), .ser_len(len_b), .ser_done(done_b),
    .tx_active(act_b), .busy(busy_b), .grant_src(gsrc_b), .frame_count(fc_b)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ack();
    int n = 0;
    while (ack_c == 2'b00 && n < 100) begin
      step();
      n++;
    end
  endtask

  task automatic serve(input string tag, input logic [W-1:0] word, input int len);
    int n = 0;
    while (!load_c && n < 100) begin
      step();
      n++;
    end
    check({tag, "_load"}, load_c, 1);
    check({tag, "_word"}, word_c, word);
    check({tag, "_len"}, len_c, len);
    check({tag, "_active"}, act_c, 1);
    repeat (19) step();
    ser_done = 1'b1;
    step();
    ser_done = 1'b0;
  endtask

  task automatic serve_frame(input string tag, input logic [W-1:0] pay);
    serve({tag, "_sync"}, exp_sync, 16);
    serve({tag, "_pay"}, pay, W);
`ifdef TX_CRC_EN
    serve({tag, "_crc"}, W'(8'hF4) << (W-8), 8);
`endif
  endtask

  task automatic tick();
    bit_tick = 1'b1;
    step();
    bit_tick = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; bit_tick = 1'b0; req = 2'b00; ser_done = 1'b0; sel = 1'b0;
    exp_sync = {16'hD391, {(W-16){1'b0}}};
`ifdef TX_CRC_EN
    packet0 = 72'h313233343536373839;
    packet1 = 72'h313233343536373839;
`else
    packet0 = 88'h0102030405060708090A0B;
    packet1 = 88'hA1A2A3A4A5A6A7A8A9AAAB;
`endif
    repeat (3) step();
    check("rst_ack", ack_c, 0);
    check("rst_load", load_c, 0);
    check("rst_word", word_c, 0);
    check("rst_busy", busy_c, 0);
    check("rst_fc", fc_c, 0);
    rst = 1'b0;
    step();

    // single request, one-cycle ack latency
    req = 2'b01;
    step();
    check("t1_ack", ack_c, 2'b01);
    check("t1_gsrc", gsrc_c, 0);
    check("t1_busy", busy_c, 1);
    req = 2'b00;
    serve_frame("t1", packet0);
    check("t1_fc", fc_c, 1);
    check("t1_active_end", act_c, 0);
    check("t1_in_gap", busy_c, 1);

    // stray completion during the gap
    ser_done = 1'b1;
    step();
    ser_done = 1'b0;
    step();
    check("stray_gap_busy", busy_c, 1);
    check("stray_gap_load", load_c, 0);
    repeat (3) begin
      tick();
      step();
    end
    check("gap_3ticks", busy_c, 1);
    tick();
    check("gap_4ticks", busy_c, 0);

    // stray completion in idle
    step();
    ser_done = 1'b1;
    step();
    ser_done = 1'b0;
    step();
    check("stray_idle_busy", busy_c, 0);
    check("stray_idle_load", load_c, 0);
    check("stray_idle_fc", fc_c, 1);

    // reset while the payload is on air
    req = 2'b01;
    step();
    check("t5_ack", ack_c, 2'b01);
    req = 2'b00;
    serve("t5_sync", exp_sync, 16);
    while (!load_c) step();
    check("t5_pay_word", word_c, packet0);
    rst = 1'b1;
    #2;
    check("t5_rst_load", load_c, 0);
    check("t5_rst_word", word_c, 0);
    check("t5_rst_len", len_c, 0);
    check("t5_rst_active", act_c, 0);
    check("t5_rst_busy", busy_c, 0);
    check("t5_rst_fc", fc_c, 0);
    #2;
    req = 2'b10;
    rst = 1'b0;
    step();
    check("t5_ack1", ack_c, 2'b10);
    check("t5_gsrc1", gsrc_c, 1);
    req = 2'b00;
    serve_frame("t5", packet1);
    check("t5_fc", fc_c, 1);
    repeat (4) tick();
    check("t5_gap_done", busy_c, 0);

    // continuous tie alternates starting with source 0
    req = 2'b11;
    for (int i = 0; i < 4; i++) begin
      wait_ack();
      check("tie_ack", ack_c, (i % 2 == 1) ? 2'b10 : 2'b01);
      check("tie_gsrc", gsrc_c, i % 2);
      step();
      check("tie_ack_pulse", ack_c, 0);
      serve_frame("tie", (i % 2 == 1) ? packet1 : packet0);
      repeat (4) tick();
      check("tie_gap_done", busy_c, 0);
    end
    req = 2'b00;
    check("tie_fc", fc_c, 5);

    // no-gap instance: back-to-back grant two cycles after the final completion
    sel = 1'b1;
    req = 2'b01;
    wait_ack();
    check("ng_ack", ack_c, 2'b01);
    step();
    serve_frame("ng", packet0);
    check("ng_idle", busy_c, 0);
    check("ng_fc", fc_c, 1);
    check("ng_no_ack_yet", ack_c, 0);
    step();
    check("ng_ack2", ack_c, 2'b01);
    req = 2'b00;
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
